// File: rtl/mac_lane_acc_if.sv
// Beat-in / result-out bundle for mac_lane_acc. The master drives beats and
// consumes results; the slave is the MAC.
interface mac_lane_acc_if #(
  parameter int unsigned LANES   = 16,
  parameter int unsigned DW      = 8,
  parameter int unsigned ACC_LEN = 4,
  parameter int unsigned BW      = 8,
  parameter int unsigned OW      = 22
);
  localparam int unsigned CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*DW-1:0]   p;
  logic [LANES*DW-1:0]   w;
  logic [BW-1:0]         b;
  logic                  relu_en;
  logic                  clr;
  logic                  out_valid;
  logic                  out_ready;
  logic [OW-1:0]         dout;
  logic [CW-1:0]         beat_idx;

  modport master (
    output in_valid, p, w, b, relu_en, clr, out_ready,
    input  in_ready, out_valid, dout, beat_idx
  );

  modport slave (
    input  in_valid, p, w, b, relu_en, clr, out_ready,
    output in_ready, out_valid, dout, beat_idx
  );
endinterface

// File: rtl/mac_lane_acc.sv
// Multi-lane MAC: per-beat dot product, ACC_LEN-beat accumulation, bias, optional
// ReLU and saturation; 3-stage pipeline with full backpressure and group abort.
module mac_lane_acc #(
  parameter int unsigned LANES   = 16,
  parameter int unsigned DW      = 8,
  parameter int unsigned ACC_LEN = 4,
  parameter int unsigned BW      = 8,
  parameter int unsigned OW      = 22
) (
  input logic           clk,
  input logic           rst,
  mac_lane_acc_if.slave bus
);
  localparam int unsigned CW   = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam int unsigned PW   = 2 * DW + 1;
  localparam int unsigned ACCW = 2 * DW + 1 + $clog2(LANES) + $clog2(ACC_LEN) + 1;
  // Result width always exceeds OW so the saturation compare is exact.
  localparam int unsigned RW   = ((ACCW > OW) ? ACCW : OW) + BW + 1;

  localparam logic [CW-1:0]        LastIdx = CW'(ACC_LEN - 1);
  localparam logic signed [RW-1:0] OutMax  = {{(RW - OW + 1){1'b0}}, {(OW - 1){1'b1}}};
  localparam logic signed [RW-1:0] OutMin  = {{(RW - OW + 1){1'b1}}, {(OW - 1){1'b0}}};

  logic                   s1_valid_q, s1_valid_d;
  logic signed [PW-1:0]   prod_q [LANES];
  logic signed [PW-1:0]   prod_d [LANES];
  logic [BW-1:0]          s1_b_q, s1_b_d;
  logic                   s1_relu_q, s1_relu_d;
  logic                   s2_valid_q, s2_valid_d;
  logic signed [ACCW-1:0] s2_sum_q, s2_sum_d;
  logic [BW-1:0]          s2_b_q, s2_b_d;
  logic                   s2_relu_q, s2_relu_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CW-1:0]          in_cnt_q, in_cnt_d;
  logic                   out_valid_q, out_valid_d;
  logic [OW-1:0]          dout_q, dout_d;

  logic                   stall;
  logic                   in_ready;
  logic                   accept;
  logic signed [PW-1:0]   mult [LANES];
  logic signed [ACCW-1:0] tree_sum;
  logic signed [RW-1:0]   res_raw;
  logic signed [RW-1:0]   res_relu;
  logic [OW-1:0]          res_sat;

  assign stall    = out_valid_q & ~bus.out_ready;
  assign in_ready = ~rst & ~stall & ~bus.clr;
  assign accept   = bus.in_valid & in_ready;

  // p lanes are unsigned, so zero-extend them before the signed multiply.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      mult[i] = $signed({{(PW - DW){1'b0}}, bus.p[i*DW +: DW]}) *
                $signed({{(PW - DW){bus.w[i*DW + DW - 1]}}, bus.w[i*DW +: DW]});
    end
  end

  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      tree_sum = tree_sum + $signed({{(ACCW - PW){prod_q[i][PW-1]}}, prod_q[i]});
    end
  end

  always_comb begin
    res_raw  = $signed({{(RW - ACCW){acc_q[ACCW-1]}}, acc_q}) +
               $signed({{(RW - ACCW){s2_sum_q[ACCW-1]}}, s2_sum_q}) +
               $signed({{(RW - BW){s2_b_q[BW-1]}}, s2_b_q});
    res_relu = (s2_relu_q && res_raw[RW-1]) ? '0 : res_raw;
    if (res_relu > OutMax) begin
      res_sat = OutMax[OW-1:0];
    end else if (res_relu < OutMin) begin
      res_sat = OutMin[OW-1:0];
    end else begin
      res_sat = res_relu[OW-1:0];
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    prod_d      = prod_q;
    s1_b_d      = s1_b_q;
    s1_relu_d   = s1_relu_q;
    s2_valid_d  = s2_valid_q;
    s2_sum_d    = s2_sum_q;
    s2_b_d      = s2_b_q;
    s2_relu_d   = s2_relu_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    in_cnt_d    = in_cnt_q;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;

    if (!stall) begin
      if (bus.out_ready) begin
        out_valid_d = 1'b0;
      end

      s1_valid_d = accept;
      if (accept) begin
        prod_d    = mult;
        s1_b_d    = bus.b;
        s1_relu_d = bus.relu_en;
        in_cnt_d  = (in_cnt_q == LastIdx) ? '0 : in_cnt_q + CW'(1);
      end

      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_sum_d  = tree_sum;
        s2_b_d    = s1_b_q;
        s2_relu_d = s1_relu_q;
      end

      // Abort drops everything in flight but leaves a pending result alone.
      if (bus.clr) begin
        s1_valid_d = 1'b0;
        s2_valid_d = 1'b0;
        acc_d      = '0;
        cnt_d      = '0;
        in_cnt_d   = '0;
      end else if (s2_valid_q) begin
        if (cnt_q == LastIdx) begin
          dout_d      = res_sat;
          out_valid_d = 1'b1;
          acc_d       = '0;
          cnt_d       = '0;
        end else begin
          acc_d = acc_q + s2_sum_q;
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      prod_q      <= '{default: '0};
      s1_b_q      <= '0;
      s1_relu_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_sum_q    <= '0;
      s2_b_q      <= '0;
      s2_relu_q   <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      prod_q      <= prod_d;
      s1_b_q      <= s1_b_d;
      s1_relu_q   <= s1_relu_d;
      s2_valid_q  <= s2_valid_d;
      s2_sum_q    <= s2_sum_d;
      s2_b_q      <= s2_b_d;
      s2_relu_q   <= s2_relu_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_cnt_q    <= in_cnt_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.beat_idx  = in_cnt_q;
endmodule

// File: doc/mac_lane_acc.md
Name: mac_lane_acc

Overview:
Parametrised successor to the 16-lane, 3-stage MAC/accumulator used in the digit-recognition datapath. Each beat takes LANES pixel/weight pairs and forms the dot product. It accumulates ACC_LEN beats, adds a signed bias once per group, and applies optional ReLU and saturation. It returns one neuron result per group over a valid/ready handshake with full backpressure, bubble tolerance and a group-abort input. It sits between the pixel/weight fetch logic and the neuron result buffer.

Parameters:
LANES, 16, multiply lanes per beat (>=1)
DW, 8, lane width; p lanes unsigned, w lanes signed two's complement
ACC_LEN, 4, beats per accumulation group (>=1)
BW, 8, bias width, signed
OW, 22, output width, signed, saturating

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid & in_ready at a rising edge
p  in  LANES*DW  pixel lanes; lane i = p[i*DW +: DW]
w  in  LANES*DW  weight lanes; lane i = w[i*DW +: DW]
b  in  BW  bias; sampled with the last beat of a group
relu_en  in  1  ReLU enable; sampled with the last beat of a group
clr  in  1  synchronous abort of the partial group
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid & out_ready
dout  out  OW  signed group result
beat_idx  out  clog2(ACC_LEN) (min 1)  index of the next beat to be accepted within the group

Behaviour:
- Internal accumulator width: ACCW = 2*DW + 1 + clog2(LANES) + clog2(ACC_LEN) + 1. No intermediate overflow is permitted.
- Pipeline has three stages, each with a valid bit:
  - S1 registers the LANES products (zero-extended p times signed w).
  - S2 registers the adder-tree sum (sumOUT, ACCW bits).
  - S3 accumulates.
- Stall: stall = out_valid & !out_ready. While stalled, all stages, the counter and dout hold.
- in_ready = !rst & !stall & !clr (combinational).
- Bubbles: a stage whose valid bit is 0 does not advance the beat counter or the accumulator.
- Beat counter: advances in S3 on each valid beat and wraps ACC_LEN-1 -> 0. beat_idx reports the accept-side count (beats accepted mod ACC_LEN).
- Last beat of a group, on reaching S3:
  - result = acc + sum + sign_extend(b).
  - If relu_en and result < 0, result = 0.
  - Saturate to [-2^(OW-1), 2^(OW-1)-1].
  - Register into dout, set out_valid, clear acc to 0.
- Other beats: acc <= acc + sum.
- Latency: the last beat accepted at edge k gives dout/out_valid updated at edge k+2, absent stall.
- Throughput: one group every ACC_LEN cycles with out_ready held high. No dead cycles between groups.
- Consume and complete on the same edge: the new result loads and out_valid stays 1.
- Consume with no completion: out_valid -> 0, dout holds its last value.
- b and relu_en travel with the last beat through the pipeline. Changing them mid-group has no effect until that group's last beat.
- clr while stalled: clr is ignored until the stall clears; the current dout is never corrupted.
- clr (not stalled) at an edge:
  - S1/S2 valid bits are cleared; acc, beat counter and beat_idx return to 0.
  - The beat presented that cycle is not accepted.
  - out_valid and dout are unaffected.
- Reset (asynchronous, any time, including mid-group or mid-stall): out_valid=0, dout=0, acc=0, all stage valid bits 0, beat counter 0, beat_idx=0, in_ready=0 while rst is high. The first beat after release starts a new group.
- ACC_LEN=1: every beat is a last beat.

Test Plan:
1. Defaults; all p lanes=0x01, w=0x01, b=11, 4 back-to-back beats, out_ready=1 -> single out_valid pulse 2 edges after beat 4; dout=75 (0x00004B).
2. p=0xFF, w=0xFF (-1) on all lanes, b=0, 4 beats: relu_en=0 -> dout=-16320 (0x3FC040); repeat with relu_en=1 -> dout=0.
3. OW=16, p=0xFF, w=0x7F on all lanes, b=0, 4 beats -> dout=0x7FFF. Default OW=22 with b=127 -> dout=2072767 (0x1FA0BF), no saturation.
4. Case-1 stimulus, out_ready=0 when the result appears -> in_ready drops, dout holds 75 for 10 cycles. Feed a second group after releasing out_ready -> second dout=75, exactly two out_valid handshakes.
5. Case-1 beats with in_valid low for 1-3 random cycles between beats -> dout=75, beat_idx sequence 1,2,3,0.
6. Assert rst asynchronously after beat 2 (mid-clock) -> outputs 0 immediately, then 4 fresh beats give dout=75. Separately, clr after beat 3 then 4 fresh beats -> dout=75 with only one result.
